// File: rtl/register_bank_array.sv
// Bank of DEPTH valid-tagged WIDTH-bit entries with indexed write, delete and read,
// plus occupancy tracking (count, full/empty, lowest free entry).
module register_bank_array #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             del_en,
  input  logic [IDX_W-1:0] del_idx,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [DEPTH-1:0] valid_mask,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) sum = sum + CNT_W'(v[i]);
    return sum;
  endfunction

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_data_nxt [DEPTH];
  logic [DEPTH-1:0] w_valid_nxt;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_rd_hit;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_free_found;

  logic [WIDTH-1:0] r_rd_data_p1;
  logic             r_rd_hit_p1;
  logic             r_rd_vld_p1;

  // Out-of-range indices never match any entry, so they fall out as no-ops.
  // Write is applied after delete so it wins on a shared index.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < DEPTH; i++) w_data_nxt[i] = r_data[i];
    if (clr) begin
      w_valid_nxt = '0;
      for (int i = 0; i < DEPTH; i++) w_data_nxt[i] = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (del_en && del_idx == IDX_W'(i)) begin
          w_valid_nxt[i] = 1'b0;
          w_data_nxt[i]  = '0;
        end
        if (wr_en && wr_idx == IDX_W'(i)) begin
          w_valid_nxt[i] = 1'b1;
          w_data_nxt[i]  = wr_data;
        end
      end
    end
  end

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        w_rd_hit  = r_valid[i];
        w_rd_word = r_valid[i] ? r_data[i] : '0;
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= popcount(w_valid_nxt);
      for (int i = 0; i < DEPTH; i++) r_data[i] <= w_data_nxt[i];
    end
  end

  // Stage p1: read result, sampled from pre-update contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_hit_p1  <= 1'b0;
      r_rd_data_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= rd_en;
      if (rd_en) begin
        r_rd_hit_p1  <= w_rd_hit;
        r_rd_data_p1 <= w_rd_word;
      end
    end
  end

  assign rd_valid   = r_rd_vld_p1;
  assign rd_hit     = r_rd_hit_p1;
  assign rd_data    = r_rd_data_p1;
  assign valid_mask = r_valid;
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign free_found = w_free_found;
  assign free_idx   = w_free_idx;

endmodule

// File: tb/tb_register_bank_array.sv
// Directed bench for register_bank_array: DEPTH=8 and DEPTH=5 instances on a shared clock/reset.
module tb_register_bank_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DEPTH=8, WIDTH=32 instance
  logic        a_clr = 0, a_wr_en = 0, a_del_en = 0, a_rd_en = 0;
  logic [2:0]  a_wr_idx = 0, a_del_idx = 0, a_rd_idx = 0;
  logic [31:0] a_wr_data = 0, a_rd_data;
  logic        a_rd_valid, a_rd_hit, a_free_found, a_full, a_empty;
  logic [7:0]  a_mask;
  logic [2:0]  a_free_idx;
  logic [3:0]  a_count;

  register_bank_array #(.WIDTH(32), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(a_clr),
    .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_data(a_wr_data),
    .del_en(a_del_en), .del_idx(a_del_idx),
    .rd_en(a_rd_en), .rd_idx(a_rd_idx),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_hit(a_rd_hit),
    .valid_mask(a_mask), .free_idx(a_free_idx), .free_found(a_free_found),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  // DEPTH=5, WIDTH=32 instance
  logic        b_clr = 0, b_wr_en = 0, b_del_en = 0, b_rd_en = 0;
  logic [2:0]  b_wr_idx = 0, b_del_idx = 0, b_rd_idx = 0;
  logic [31:0] b_wr_data = 0, b_rd_data;
  logic        b_rd_valid, b_rd_hit, b_free_found, b_full, b_empty;
  logic [4:0]  b_mask;
  logic [2:0]  b_free_idx;
  logic [2:0]  b_count;

  register_bank_array #(.WIDTH(32), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
    .del_en(b_del_en), .del_idx(b_del_idx),
    .rd_en(b_rd_en), .rd_idx(b_rd_idx),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_hit(b_rd_hit),
    .valid_mask(b_mask), .free_idx(b_free_idx), .free_found(b_free_found),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked 1ns after the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    tick();
    tick();
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_free_found", a_free_found, 1);
    chk("rst_free_idx", a_free_idx, 0);
    chk("rst_mask", a_mask, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_rd_hit", a_rd_hit, 0);
    chk("rst_rd_data", a_rd_data, 0);
    rst_n = 1'b1;

    // Fill all eight entries
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1; a_wr_idx = 3'(i); a_wr_data = 32'hA0 + 32'(i);
      tick();
    end
    a_wr_en = 0;
    chk("fill_count", a_count, 8);
    chk("fill_full", a_full, 1);
    chk("fill_free_found", a_free_found, 0);
    chk("fill_free_idx", a_free_idx, 0);
    chk("fill_mask", a_mask, 8'hFF);
    chk("fill_empty", a_empty, 0);

    a_rd_en = 1; a_rd_idx = 5;
    tick();
    a_rd_en = 0;
    chk("rd5_valid", a_rd_valid, 1);
    chk("rd5_hit", a_rd_hit, 1);
    chk("rd5_data", a_rd_data, 32'hA5);
    tick();
    chk("rd_pulse_end", a_rd_valid, 0);
    chk("rd_hold_data", a_rd_data, 32'hA5);
    chk("rd_hold_hit", a_rd_hit, 1);

    // Delete from full, then concurrent write/delete at different indices
    a_del_en = 1; a_del_idx = 3;
    tick();
    chk("del3_count", a_count, 7);
    chk("del3_free_idx", a_free_idx, 3);
    chk("del3_full", a_full, 0);
    a_wr_en = 1; a_wr_idx = 3; a_wr_data = 32'hBB; a_del_idx = 6;
    tick();
    a_wr_en = 0; a_del_en = 0;
    chk("wd_count", a_count, 7);
    chk("wd_free_idx", a_free_idx, 6);
    chk("wd_mask", a_mask, 8'hBF);
    a_rd_en = 1; a_rd_idx = 3;
    tick();
    a_rd_en = 0;
    chk("rd3_data", a_rd_data, 32'hBB);
    chk("rd3_hit", a_rd_hit, 1);

    // Write and delete on the same index: write wins
    a_wr_en = 1; a_wr_idx = 6; a_wr_data = 32'hCC; a_del_en = 1; a_del_idx = 6;
    tick();
    a_wr_en = 0; a_del_en = 0;
    chk("wdsame_count", a_count, 8);
    chk("wdsame_mask", a_mask, 8'hFF);
    a_rd_en = 1; a_rd_idx = 6;
    tick();
    a_rd_en = 0;
    chk("rd6_data", a_rd_data, 32'hCC);

    // Overwrite while full, then read-before-write on the same index
    a_wr_en = 1; a_wr_idx = 2; a_wr_data = 32'h11;
    tick();
    chk("ow1_count", a_count, 8);
    a_wr_data = 32'h22; a_rd_en = 1; a_rd_idx = 2;
    tick();
    a_wr_en = 0;
    chk("rbw_data", a_rd_data, 32'h11);
    chk("ow2_count", a_count, 8);
    tick();
    a_rd_en = 0;
    chk("rd2_new_data", a_rd_data, 32'h22);

    // Read of a deleted entry, and deleting an already-invalid entry
    a_del_en = 1; a_del_idx = 0;
    tick();
    a_rd_en = 1; a_rd_idx = 0;
    tick();
    a_del_en = 0; a_rd_en = 0;
    chk("rd_inv_hit", a_rd_hit, 0);
    chk("rd_inv_data", a_rd_data, 0);
    chk("del_inv_count", a_count, 7);
    chk("del_inv_free_idx", a_free_idx, 0);

    // Clear with a concurrent write, starting from four valid entries
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("clr0_count", a_count, 0);
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_idx = 3'(i + 2); a_wr_data = 32'h50 + 32'(i);
      tick();
    end
    chk("four_count", a_count, 4);
    chk("four_mask", a_mask, 8'h3C);
    a_clr = 1; a_wr_idx = 1; a_wr_data = 32'h77;
    tick();
    a_clr = 0; a_wr_en = 0;
    chk("clrwr_count", a_count, 0);
    chk("clrwr_empty", a_empty, 1);
    chk("clrwr_mask", a_mask, 0);

    // Reset pulse while a read result is pending
    a_wr_en = 1; a_wr_idx = 1; a_wr_data = 32'h99;
    tick();
    a_wr_en = 0; a_rd_en = 1; a_rd_idx = 1;
    tick();
    a_rd_en = 0;
    chk("pre_rst_valid", a_rd_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", a_rd_valid, 0);
    chk("mid_rst_hit", a_rd_hit, 0);
    chk("mid_rst_data", a_rd_data, 0);
    chk("mid_rst_count", a_count, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", a_rd_valid, 0);
    a_wr_en = 1; a_wr_idx = 4; a_wr_data = 32'h44;
    tick();
    a_wr_en = 0;
    chk("post_rst_write_count", a_count, 1);
    chk("post_rst_free_idx", a_free_idx, 0);

    // DEPTH=5: out-of-range write/read, then fill
    b_wr_en = 1; b_wr_idx = 6; b_wr_data = 32'hDEAD;
    tick();
    b_wr_en = 0;
    chk("d5_oor_wr_count", b_count, 0);
    chk("d5_oor_wr_mask", b_mask, 0);
    b_rd_en = 1; b_rd_idx = 7;
    tick();
    b_rd_en = 0;
    chk("d5_oor_rd_valid", b_rd_valid, 1);
    chk("d5_oor_rd_hit", b_rd_hit, 0);
    chk("d5_oor_rd_data", b_rd_data, 0);
    for (int i = 0; i < 5; i++) begin
      b_wr_en = 1; b_wr_idx = 3'(i); b_wr_data = 32'h10 + 32'(i);
      tick();
    end
    b_wr_en = 0;
    chk("d5_full", b_full, 1);
    chk("d5_count", b_count, 5);
    chk("d5_free_found", b_free_found, 0);
    chk("d5_mask", b_mask, 5'h1F);
    b_del_en = 1; b_del_idx = 7;
    tick();
    b_del_en = 0;
    chk("d5_oor_del_count", b_count, 5);
    b_rd_en = 1; b_rd_idx = 4;
    tick();
    b_rd_en = 0;
    chk("d5_rd4_data", b_rd_data, 32'h14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
